// File: rtl/table_mem_arbiter.sv
// Two-requester arbiter in front of a single-port table memory.
// Grants are combinational from the live requests and the burst state; the
// burst limit keeps one requester from starving the other under contention.
// Read data returns one cycle after the grant and is steered by a registered
// pending tag.
module table_mem_arbiter #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 37,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              r0_req,
    input  logic              r0_wr,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,

    input  logic              r1_req,
    input  logic              r1_wr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,

    output logic              mem_enable,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [3:0] MaxBurstCnt = 4'(MAX_BURST);
    localparam logic [3:0] CntSat      = 4'd15;

    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic       pend_id_q, pend_id_d;

    logic              gnt_valid;
    logic              gnt_id;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              burst_open;

    // The current holder keeps the memory only while its burst is live and below the limit.
    assign burst_open = (cnt_q != 4'd0) && (cnt_q < MaxBurstCnt);

    // Arbitration; grants are suppressed while reset is held.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (rst_n) begin
            if (r0_req && r1_req) begin
                gnt_valid = 1'b1;
                gnt_id    = burst_open ? last_q : ~last_q;
            end else if (r0_req) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (r1_req) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
    end

    // Select the granted requester's command.
    always_comb begin
        sel_wr    = r0_wr;
        sel_addr  = r0_addr;
        sel_wdata = r0_wdata;
        if (gnt_id) begin
            sel_wr    = r1_wr;
            sel_addr  = r1_addr;
            sel_wdata = r1_wdata;
        end
    end

    assign r0_gnt = gnt_valid & ~gnt_id;
    assign r1_gnt = gnt_valid & gnt_id;

    // Memory command is zeroed on idle cycles.
    always_comb begin
        mem_enable     = gnt_valid;
        mem_wr_en      = gnt_valid & sel_wr;
        mem_addr       = gnt_valid ? sel_addr : '0;
        mem_write_data = gnt_valid ? sel_wdata : '0;
    end

    // Burst bookkeeping and read-pending tag for the next cycle.
    always_comb begin
        last_d    = last_q;
        cnt_d     = cnt_q;
        pend_d    = 1'b0;
        pend_id_d = pend_id_q;
        if (gnt_valid) begin
            last_d = gnt_id;
            if (gnt_id == last_q) begin
                cnt_d = (cnt_q == CntSat) ? CntSat : cnt_q + 4'd1;
            end else begin
                cnt_d = 4'd1;
            end
            if (!sel_wr) begin
                pend_d    = 1'b1;
                pend_id_d = gnt_id;
            end
        end else begin
            cnt_d = 4'd0;
        end
    end

    // State registers; reset leaves requester 1 as last so contention favours 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= 1'b1;
            cnt_q     <= 4'd0;
            pend_q    <= 1'b0;
            pend_id_q <= 1'b0;
        end else begin
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_id_q <= pend_id_d;
        end
    end

    assign r0_rvalid = pend_q & ~pend_id_q;
    assign r1_rvalid = pend_q & pend_id_q;
    assign r0_rdata  = mem_read_data;
    assign r1_rdata  = mem_read_data;

endmodule

// File: doc/table_mem_arbiter.md
TABLE_MEM_ARBITER -- requirements
Module: table_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, memory word address width.
REQ-002 SHALL have parameter DATA_W, default 37, memory word width.
REQ-003 SHALL have parameter MAX_BURST, default 4, legal range 1..15, max consecutive grants to one requester while the other waits.
REQ-004 SHALL have ports: clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have, for N in {0,1}: rN_req  in  1  access request.
REQ-007 SHALL have rN_wr  in  1  1=write, 0=read.
REQ-008 SHALL have rN_addr  in  ADDR_W  word address.
REQ-009 SHALL have rN_wdata  in  DATA_W  write data.
REQ-010 SHALL have rN_gnt  out  1  access accepted this cycle.
REQ-011 SHALL have rN_rvalid  out  1  read data valid for requester N.
REQ-012 SHALL have rN_rdata  out  DATA_W  read data.
REQ-013 SHALL have memory side (memory_if src semantics): mem_enable  out  1; mem_wr_en  out  1; mem_addr  out  ADDR_W; mem_write_data  out  DATA_W; mem_read_data  in  DATA_W, valid one cycle after a read enable.

Function
REQ-014 SHALL grant at most one requester per cycle; rN_gnt combinational from current requests and registered state.
REQ-015 SHALL keep state: last (1 bit, last granted requester) and cnt (4 bits, consecutive grants to last).
REQ-016 Single requester N asserting: SHALL grant N.
REQ-017 Both asserting: SHALL grant last if 0 < cnt < MAX_BURST; otherwise grant ~last.
REQ-018 On a grant to N: last <= N; cnt <= (N==last) ? min(cnt+1,15) : 1.
REQ-019 On a cycle with no grant: cnt <= 0; last unchanged.
REQ-020 Granted cycle: mem_enable=1, mem_wr_en=rN_wr, mem_addr=rN_addr, mem_write_data=rN_wdata of granted N; no grant: all mem outputs 0.
REQ-021 A write SHALL complete at the granting edge; no response beyond rN_gnt.
REQ-022 A granted read SHALL set registered pend=1, pend_id=N; next cycle rN_rvalid=1 for N==pend_id only; pend cleared if no read granted.
REQ-023 rN_rdata SHALL equal mem_read_data (both ports, unconditioned); meaningful only with rN_rvalid.
REQ-024 Back-to-back reads SHALL be supported at one per cycle with no bubble.
REQ-025 Requester SHALL hold req/wr/addr/wdata stable until gnt; arbiter does not check this; a dropped ungranted request is simply not serviced.
REQ-026 rN_req and rN_gnt on the same N in the same cycle with last update SHALL not depend on rN_rvalid.

Reset
REQ-027 On rst_n=0, asynchronously: last=1, cnt=0, pend=0, pend_id=0; hence all rN_gnt/rN_rvalid/mem_* outputs 0 while rst_n=0.
REQ-028 A read granted in the cycle reset asserts SHALL produce no rN_rvalid after reset releases.
REQ-029 First contention after reset SHALL grant requester 0.

Verification
REQ-030 Reset then r0 read addr 3 alone -> r0_gnt same cycle, mem_enable=1 mem_wr_en=0 mem_addr=3; next cycle r0_rvalid=1, r1_rvalid=0, r0_rdata=mem_read_data.
REQ-031 Both request continuously, MAX_BURST=4 -> grant pattern 0,0,0,0,1,1,1,1,0... ; never two gnts in one cycle.
REQ-032 MAX_BURST=1, both request continuously -> strict alternation 0,1,0,1 starting with 0.
REQ-033 r1 write addr 7 data 37'h1F_0000_0001 -> r1_gnt, mem_wr_en=1, mem_write_data matches; no rvalid next cycle.
REQ-034 r0 read granted, rst_n asserted in that cycle and released two cycles later -> r0_rvalid stays 0; cnt=0, last=1 after release.
REQ-035 Alternating reads r0 addr 2 / r1 addr 5 on consecutive cycles -> rvalid toggles between ports each cycle with correct data, no idle cycle.
